// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder for the multicycle MIPS core.
// Accepts one load/store at a time, waits WAIT cycles, performs the byte-lane
// access on an internal word array and returns the response over valid/ready.
// Optional build macro: DM_ALIGN_CHECK_EN. When defined, misaligned accesses
// complete with rsp_err=1 and no write. When undefined, low address bits are
// ignored and rsp_err is tied to 0.
module dm_responder #(
    parameter int ADDR_W = 12,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;

    // Latched request
    logic              we_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;

    // Word array, little-endian lanes; deliberately not reset
    logic [31:0]       mem [DEPTH];

    // Access decode
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        lane_off;
    logic              bad;
    logic              access;
    logic [3:0]        lane_en;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_val;

`ifdef DM_ALIGN_CHECK_EN
    logic              err_q;
    assign rsp_err = err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign word_idx = addr_q[ADDR_W-1:2];
    assign access   = (state == BUSY) && (cnt == '0);
    assign rd_word  = mem[word_idx];

    // Effective lane offset and alignment error for the latched request
    always_comb begin
        lane_off = addr_q[1:0];
        case (size_q)
            2'b00:   lane_off = addr_q[1:0];
            2'b01:   lane_off = {addr_q[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
`ifdef DM_ALIGN_CHECK_EN
        case (size_q)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr_q[0];
            default: bad = |addr_q[1:0];
        endcase
`else
        bad = 1'b0;
`endif
    end

    // Store lane enables and lane-replicated write data
    always_comb begin
        lane_en = 4'b1111;
        wr_word = wdata_q;
        case (size_q)
            2'b00: begin
                lane_en = 4'b0001 << lane_off;
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_en = lane_off[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_en = 4'b1111;
                wr_word = wdata_q;
            end
        endcase
    end

    // Load extraction with sign or zero extension
    always_comb begin
        case (lane_off)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane_off[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            2'b00:   load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
            2'b01:   load_val = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Commit stores on the access edge; reset on the same edge suppresses the write
    always_ff @(posedge clk) begin
        if (!rst && access && we_q && !bad) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Request/wait/response sequencing with registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DM_ALIGN_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        wdata_q   <= req_wdata;
                        cnt       <= WAIT_CNT;
                        req_ready <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_rdata <= (we_q || bad) ? '0 : load_val;
`ifdef DM_ALIGN_CHECK_EN
                        err_q     <= bad;
`endif
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Testbench for dm_responder: randomized load/store traffic against a
// byte-level reference model, scoreboard queue checked by a response monitor.
// Honours DM_ALIGN_CHECK_EN the same way the design does.
`timescale 1ns/1ps
module tb_dm_responder;

    localparam int ADDR_W = 12;
    localparam int WAIT_C = 2;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    dm_responder #(.ADDR_W(ADDR_W), .WAIT(WAIT_C)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    typedef struct {
        logic [31:0] rd;
        bit          err;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        cur;
    logic [7:0]  mb [256];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          in_resp  = 0;
    bit          exp_idle = 0;
    bit          force_low = 0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic finish_test();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting, got no event expected one (cycle %0d)", nm, cyc);
        finish_test();
    endtask

    // Reference model: byte-addressed memory, access size in bytes
    task automatic model(input bit we, input int addr, input int size, input bit sgn,
                         input logic [31:0] wd, output logic [31:0] rd, output bit err);
        int     n;
        int     base;
        longint v;
        n   = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        rd  = '0;
        err = 0;
`ifdef DM_ALIGN_CHECK_EN
        if (addr % n != 0) begin
            err = 1;
            return;
        end
        base = addr;
`else
        base = addr - (addr % n);
`endif
        if (we) begin
            for (int i = 0; i < n; i++) mb[(base + i) & 255] = wd[8*i +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v | (longint'(mb[(base + i) & 255]) << (8 * i));
            if (sgn && v[8*n-1]) v = v - (longint'(1) << (8 * n));
            rd = v[31:0];
        end
    endtask

    // Random response back-pressure, overridable to hold the responder in RESP
    initial begin
        rsp_ready = 0;
        forever begin
            @(posedge clk);
            #2;
            rsp_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Response monitor: pops the scoreboard on each new response and checks it
    always @(negedge clk) begin
        if (rst) begin
            in_resp  = 0;
            exp_idle = 0;
        end else begin
            if (exp_idle) begin
                exp_idle = 0;
                chk("release_rsp_valid", rsp_valid, 0);
                chk("release_req_ready", req_ready, 1);
            end
            if (rsp_valid) begin
                if (!in_resp) begin
                    if (sbq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                        cur.rd  = rsp_rdata;
                        cur.err = rsp_err;
                        cur.acc = cyc - WAIT_C - 1;
                    end else begin
                        cur = sbq.pop_front();
                        chk("latency", cyc, cur.acc + WAIT_C + 1);
                    end
                    in_resp = 1;
                end
                chk("rsp_rdata", rsp_rdata, cur.rd);
                chk("rsp_err", rsp_err, cur.err);
                chk("req_ready_in_resp", req_ready, 0);
                if (rsp_ready) begin
                    in_resp  = 0;
                    exp_idle = 1;
                end
            end
        end
    end

    // Present a request at the current negedge and hold it until accepted
    task automatic issue(input bit we, input int addr, input int size, input bit sgn,
                         input logic [31:0] wd, input bit track);
        exp_t e;
        int   waited;
        req_we     = we;
        req_addr   = ADDR_W'(addr);
        req_size   = 2'(size);
        req_signed = sgn;
        req_wdata  = wd;
        req_valid  = 1;
        waited     = 0;
        while (!req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 100) timeout("req_accept");
        end
        @(negedge clk);
        req_valid = 0;
        if (track) begin
            model(we, addr, size, sgn, wd, e.rd, e.err);
            e.acc = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sbq.size() != 0 || in_resp || !req_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) timeout("drain");
        end
    endtask

    initial begin
        int waited;
        rst = 1; req_valid = 0; req_we = 0; req_addr = '0;
        req_size = '0; req_signed = 0; req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);

        // A request coinciding with reset must be ignored
        req_valid = 1;
        @(negedge clk);
        chk("rst_req_ignored", req_ready, 1);
        req_valid = 0;
        rst = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_no_rsp", rsp_valid, 0);

        // Initialise bytes 0x00..0xFF, word 0x40 holds 0x8899AABB
        for (int w = 0; w < 64; w++) begin
            issue(1, w * 4, 2, 0, (w == 16) ? 32'h8899AABB : $urandom, 1);
        end
        drain();

        issue(0, 'h41, 0, 1, '0, 1);
        issue(0, 'h41, 0, 0, '0, 1);
        issue(1, 'h42, 1, 0, 32'hFFFF1234, 1);
        issue(0, 'h40, 2, 0, '0, 1);
        drain();
        chk("plan_word_40", {mb['h43], mb['h42], mb['h41], mb['h40]}, 32'h1234AABB);

        // Hold the response, a second request must stay pending
        force_low = 1;
        issue(0, 'h40, 2, 0, '0, 1);
        waited = 0;
        while (!rsp_valid) begin
            @(negedge clk);
            waited++;
            if (waited > 50) timeout("stall_rsp_valid");
        end
        req_we = 0; req_addr = 'h41; req_size = 0; req_signed = 1; req_valid = 1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_rsp_valid", rsp_valid, 1);
        end
        force_low = 0;
        issue(0, 'h41, 0, 1, '0, 1);
        drain();

        // Reset while a store is waiting discards it
        issue(1, 'h80, 2, 0, 32'hDEADBEEF, 0);
        rst = 1;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_rsp_rdata", rsp_rdata, 0);
        chk("midrst_rsp_err", rsp_err, 0);
        rst = 0;
        @(negedge clk);
        issue(0, 'h80, 2, 0, '0, 1);
        drain();

        // Misaligned word store: error (check build) or aligned-down write
        issue(1, 'h42, 2, 0, 32'hCAFEF00D, 1);
        issue(0, 'h40, 2, 0, '0, 1);
        drain();

        // Random traffic
        for (int k = 0; k < 150; k++) begin
            issue($urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom, 1);
        end
        drain();
        repeat (3) @(negedge clk);
        finish_test();
    end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder for the multicycle MIPS core: the memory side of the core's load/store interface. It accepts one load or store request at a time over a valid/ready handshake and holds it for a fixed, parameterised number of wait states. It then performs the byte-lane access on an internal word array and returns a response over a second valid/ready handshake. For loads, the response carries size-extracted, sign- or zero-extended data.

## Interface
Parameters:
- `ADDR_W`, 12, byte-address width; the array holds 2^(ADDR_W-2) 32-bit words.
- `WAIT`, 2, extra wait cycles between request accept and memory access (0..15).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  ADDR_W  byte address.
- `req_size`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- `req_signed`  in  1  load extension: 1 = sign, 0 = zero.
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  requester takes the response.
- `rsp_rdata`  out  32  load result; 0 for stores and errors.
- `rsp_err`  out  1  access error (only when `DM_ALIGN_CHECK_EN` is defined; otherwise tied to 0).

## Operation
- The FSM has three states, IDLE, BUSY and RESP. Reset enters IDLE.
- IDLE:
  - `req_ready`=1.
  - On an edge with `req_valid`=1, latch we/addr/size/signed/wdata, load the counter with `WAIT`, and go to BUSY.
- BUSY:
  - `req_ready`=0, `rsp_valid`=0.
  - Counter != 0: decrement.
  - Counter == 0: perform the access on this edge and go to RESP.
- Access, using the word index `addr[ADDR_W-1:2]` and the byte offset `addr[1:0]`:
  - Lanes are little-endian: offset k maps to bits [8k+7:8k].
  - Store byte: write `wdata[7:0]` to lane k only.
  - Store half: write `wdata[15:0]` to lanes {1,0} if addr[1]=0, else lanes {3,2}.
  - Store word: write all lanes.
  - Unselected lanes are unchanged.
  - Load: extract the selected byte or half into the low bits. Upper bits are the MSB of the extracted field if `signed`=1, else 0. Register the result into `rsp_rdata`.
  - Reserved size 11 is treated as word.
- RESP:
  - `rsp_valid`=1. `rsp_rdata` and `rsp_err` are held stable until the handshake.
  - On an edge with `rsp_ready`=1, go to IDLE and clear `rsp_valid`.
- At most one request is outstanding at a time. A request presented outside IDLE is not accepted and must be held by the requester.
- The array is not cleared by reset. Its initial contents are undefined in hardware; the bench may preload it with `$readmemh`.

## Timing
- Outputs after reset: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter 0.
- Latency:
  - A request accepted at edge N is accessed at edge N+WAIT+1.
  - `rsp_valid` is 1 from the cycle after that edge.
  - With `rsp_ready` held high, `req_ready` returns to 1 after edge N+WAIT+2.
  - Minimum request-to-request spacing is WAIT+3 cycles.
- A store takes effect in the array at the access edge. A load issued after that store observes the new value.
- Reset has priority on any edge:
  - The FSM returns to IDLE and all outputs return to their reset values.
  - A store still in BUSY is discarded; the array is not written.
  - A store already committed stays committed.
- A request arriving on the same edge that `rst`=1 is not accepted.
- RESP with `rsp_ready`=0 stalls indefinitely with no change to any output.

## Configuration
- `DM_ALIGN_CHECK_EN` defined:
  - A misaligned access (half with addr[0]=1, word or reserved size with addr[1:0]!=0) completes with `rsp_err`=1 and `rsp_rdata`=0.
  - A misaligned store writes nothing.
  - Latency is unchanged.
- `DM_ALIGN_CHECK_EN` undefined:
  - `rsp_err` is constant 0.
  - Address bits below the access size are forced to 0 (half ignores addr[0], word ignores addr[1:0]), and the access proceeds as aligned.

## Test plan
- Preload word 0x10 (byte addr 0x40) with 0x8899AABB. Load byte, signed, addr 0x41 -> rdata 0xFFFFFFAA. Same load unsigned -> 0x000000AA.
- Store half 0x1234 at 0x42, then load word 0x40 -> 0x1234AABB. `rsp_valid` rises exactly WAIT+1 edges after each accept (WAIT=2: third edge).
- Hold `rsp_ready`=0 for 5 cycles in RESP -> `rsp_valid`/`rsp_rdata` stable, `req_ready`=0 throughout, second `req_valid` not accepted. Release -> IDLE next edge.
- Assert `rst` one cycle after accepting store word 0xDEADBEEF to 0x80 -> outputs at reset values next cycle. Load 0x80 -> prior contents, unchanged.
- With `DM_ALIGN_CHECK_EN`: store word at 0x42 -> `rsp_err`=1, array unchanged. Without it: same store writes 0x40, `rsp_err`=0.
